// File: rtl/miner_job_master.sv
// miner_job_master
// Avalon-MM master that loads one mining job into the miner's register-mapped
// slave and polls it until the job is complete.
//   clk, rst                   : clock, synchronous active-high reset
//   job_valid/job_ready        : job handshake; job_target (256b) and
//                                job_message (608b) are latched on acceptance
//   result_valid/result_ready  : result handshake; result_found,
//                                result_timeout and result_nonce stay stable
//                                while result_valid is high
//   m_address .. m_chipselect  : Avalon-MM master strobes, all registered
//   m_readdata                 : slave read data, READ_LATENCY cycles after m_read
// Bus sequence per job: 0->addr1, target words to 2..9, message words to
// 11..29, 1->addr1, 3->addr1, then status polls at STATUS_ADDR, and a nonce
// read at NONCE_ADDR when the miner reports found.
module miner_job_master #(
    parameter int unsigned POLL_INTERVAL = 8,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned TIMEOUT_POLLS = 65535,
    parameter int unsigned STATUS_ADDR   = 0,
    parameter int unsigned NONCE_ADDR    = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_target,
    input  logic [607:0] job_message,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         result_found,
    output logic         result_timeout,
    output logic [31:0]  result_nonce,
    output logic [4:0]   m_address,
    output logic [31:0]  m_writedata,
    output logic         m_write,
    output logic         m_read,
    output logic         m_chipselect,
    input  logic [31:0]  m_readdata
);

    localparam logic [15:0] WAIT_LAST   = 16'(POLL_INTERVAL - 1);
    localparam logic [1:0]  LAT_LAST    = 2'(READ_LATENCY - 1);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_POLLS);
    localparam logic [4:0]  ST_ADDR     = 5'(STATUS_ADDR);
    localparam logic [4:0]  NC_ADDR     = 5'(NONCE_ADDR);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_CLR          = 4'd1,
        S_WR_TGT       = 4'd2,
        S_WR_MSG       = 4'd3,
        S_LT           = 4'd4,
        S_LM           = 4'd5,
        S_WAIT         = 4'd6,
        S_RD_ST        = 4'd7,
        S_RD_ST_LAT    = 4'd8,
        S_RD_NONCE     = 4'd9,
        S_RD_NONCE_LAT = 4'd10,
        S_DONE         = 4'd11
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [15:0]    wait_q, wait_d;
    logic [1:0]     lat_q, lat_d;
    logic [15:0]    poll_q, poll_d;
    logic [255:0]   tgt_q, tgt_d;
    logic [607:0]   msg_q, msg_d;
    logic           found_q, found_d;
    logic           timeout_q, timeout_d;
    logic [31:0]    nonce_q, nonce_d;
    logic           result_valid_q, result_valid_d;
    logic           job_ready_q, job_ready_d;
    logic [4:0]     m_address_q, m_address_d;
    logic [31:0]    m_writedata_q, m_writedata_d;
    logic           m_write_q, m_write_d;
    logic           m_read_q, m_read_d;
    logic           m_cs_q, m_cs_d;

    // Next-state logic: sequencing, counters, job latch and result capture.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        lat_d     = lat_q;
        poll_d    = poll_q;
        tgt_d     = tgt_q;
        msg_d     = msg_q;
        found_d   = found_q;
        timeout_d = timeout_q;
        nonce_d   = nonce_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid && job_ready_q) begin
                    tgt_d     = job_target;
                    msg_d     = job_message;
                    found_d   = 1'b0;
                    timeout_d = 1'b0;
                    nonce_d   = 32'd0;
                    state_d   = S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                idx_d   = 5'd0;
                state_d = S_WR_TGT;
            end
            S_WR_TGT: begin
                if (idx_q == 5'd7) begin
                    idx_d   = 5'd0;
                    state_d = S_WR_MSG;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_WR_MSG: begin
                if (idx_q == 5'd18) begin
                    idx_d   = 5'd0;
                    state_d = S_LT;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_LT: begin
                state_d = S_LM;
            end
            S_LM: begin
                wait_d  = 16'd0;
                poll_d  = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_RD_ST;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_RD_ST: begin
                lat_d   = 2'd0;
                state_d = S_RD_ST_LAT;
            end
            S_RD_ST_LAT: begin
                // Read data is sampled at the end of the last latency cycle.
                if (lat_q == LAT_LAST) begin
                    if (m_readdata[1]) begin
                        if (m_readdata[0]) begin
                            state_d = S_RD_NONCE;
                        end else begin
                            found_d = 1'b0;
                            nonce_d = 32'd0;
                            state_d = S_DONE;
                        end
                    end else begin
                        poll_d = poll_q + 16'd1;
                        if ((poll_q + 16'd1) == TIMEOUT_CNT) begin
                            timeout_d = 1'b1;
                            found_d   = 1'b0;
                            nonce_d   = 32'd0;
                            state_d   = S_DONE;
                        end else begin
                            wait_d  = 16'd0;
                            state_d = S_WAIT;
                        end
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_RD_NONCE: begin
                lat_d   = 2'd0;
                state_d = S_RD_NONCE_LAT;
            end
            S_RD_NONCE_LAT: begin
                if (lat_q == LAT_LAST) begin
                    found_d   = 1'b1;
                    timeout_d = 1'b0;
                    nonce_d   = m_readdata;
                    state_d   = S_DONE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    found_d   = 1'b0;
                    timeout_d = 1'b0;
                    nonce_d   = 32'd0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every strobe is registered
    // and lines up with the state that owns it.
    always_comb begin
        m_address_d    = 5'd0;
        m_writedata_d  = 32'd0;
        m_write_d      = 1'b0;
        m_read_d       = 1'b0;
        result_valid_d = (state_d == S_DONE);
        job_ready_d    = (state_d == S_IDLE);
        case (state_d)
            S_CLR: begin
                m_write_d     = 1'b1;
                m_address_d   = 5'd1;
                m_writedata_d = 32'd0;
            end
            S_WR_TGT: begin
                m_write_d     = 1'b1;
                m_address_d   = 5'd2 + idx_d;
                m_writedata_d = tgt_q[{idx_d[2:0], 5'd0} +: 32];
            end
            S_WR_MSG: begin
                m_write_d     = 1'b1;
                m_address_d   = 5'd11 + idx_d;
                m_writedata_d = msg_q[{idx_d, 5'd0} +: 32];
            end
            S_LT: begin
                m_write_d     = 1'b1;
                m_address_d   = 5'd1;
                m_writedata_d = 32'd1;
            end
            S_LM: begin
                // bit0 stays set so only the newMsg bit sees a rising edge
                m_write_d     = 1'b1;
                m_address_d   = 5'd1;
                m_writedata_d = 32'd3;
            end
            S_RD_ST: begin
                m_read_d    = 1'b1;
                m_address_d = ST_ADDR;
            end
            S_RD_NONCE: begin
                m_read_d    = 1'b1;
                m_address_d = NC_ADDR;
            end
            default: begin
                m_write_d = 1'b0;
                m_read_d  = 1'b0;
            end
        endcase
        m_cs_d = m_write_d | m_read_d;
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= 5'd0;
            wait_q         <= 16'd0;
            lat_q          <= 2'd0;
            poll_q         <= 16'd0;
            tgt_q          <= 256'd0;
            msg_q          <= 608'd0;
            found_q        <= 1'b0;
            timeout_q      <= 1'b0;
            nonce_q        <= 32'd0;
            result_valid_q <= 1'b0;
            job_ready_q    <= 1'b1;
            m_address_q    <= 5'd0;
            m_writedata_q  <= 32'd0;
            m_write_q      <= 1'b0;
            m_read_q       <= 1'b0;
            m_cs_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wait_q         <= wait_d;
            lat_q          <= lat_d;
            poll_q         <= poll_d;
            tgt_q          <= tgt_d;
            msg_q          <= msg_d;
            found_q        <= found_d;
            timeout_q      <= timeout_d;
            nonce_q        <= nonce_d;
            result_valid_q <= result_valid_d;
            job_ready_q    <= job_ready_d;
            m_address_q    <= m_address_d;
            m_writedata_q  <= m_writedata_d;
            m_write_q      <= m_write_d;
            m_read_q       <= m_read_d;
            m_cs_q         <= m_cs_d;
        end
    end

    assign job_ready      = job_ready_q;
    assign result_valid   = result_valid_q;
    assign result_found   = found_q;
    assign result_timeout = timeout_q;
    assign result_nonce   = nonce_q;
    assign m_address      = m_address_q;
    assign m_writedata    = m_writedata_q;
    assign m_write        = m_write_q;
    assign m_read         = m_read_q;
    assign m_chipselect   = m_cs_q;

endmodule

// File: tb/tb_miner_job_master.sv
// tb_miner_job_master
// Drives jobs into miner_job_master against a small Avalon slave model that
// scripts the status word per job, records every bus access, and checks
// the write sequence, poll timing, result values and handshake behaviour.
module tb_miner_job_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_target;
    logic [607:0] job_message;
    logic         result_valid;
    logic         result_ready;
    logic         result_found;
    logic         result_timeout;
    logic [31:0]  result_nonce;
    logic [4:0]   m_address;
    logic [31:0]  m_writedata;
    logic         m_write;
    logic         m_read;
    logic         m_chipselect;
    logic [31:0]  m_readdata;

    always #5 clk = ~clk;

    miner_job_master #(
        .POLL_INTERVAL(8),
        .READ_LATENCY (1),
        .TIMEOUT_POLLS(5),
        .STATUS_ADDR  (0),
        .NONCE_ADDR   (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_target    (job_target),
        .job_message   (job_message),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_found  (result_found),
        .result_timeout(result_timeout),
        .result_nonce  (result_nonce),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_write       (m_write),
        .m_read        (m_read),
        .m_chipselect  (m_chipselect),
        .m_readdata    (m_readdata)
    );

    int errors = 0;
    int checks = 0;

    // Slave model state: status script per job, read-data pipeline.
    int          cyc = 0;
    int          hs_edge = 0;
    int          st_total = 0;
    int          st_base = 0;
    int          zero_polls = 0;
    logic [31:0] final_status = 32'd0;
    logic [31:0] nonce_val = 32'd0;
    logic [31:0] rdata_q = 32'd0;
    assign m_readdata = rdata_q;

    // Edge counter, handshake edge capture and one-cycle read response.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && job_valid && job_ready) hs_edge <= cyc + 1;
        if (m_read) begin
            if (m_address == 5'd0) begin
                rdata_q  <= ((st_total - st_base) < zero_polls) ? 32'd0 : final_status;
                st_total <= st_total + 1;
            end else if (m_address == 5'd10) begin
                rdata_q <= nonce_val;
            end else begin
                rdata_q <= 32'hBAD0_0000;
            end
        end
    end

    localparam int TRMAX = 1024;
    logic        tr_we   [TRMAX];
    logic [4:0]  tr_addr [TRMAX];
    logic [31:0] tr_data [TRMAX];
    int          tr_cyc  [TRMAX];
    int          tr_n = 0;
    int          bus_viol = 0;

    // Bus trace capture mid-cycle; cyc equals the edge that launched the access.
    always @(negedge clk) begin
        if ((m_write || m_read) && tr_n < TRMAX) begin
            tr_we[tr_n]   <= m_write;
            tr_addr[tr_n] <= m_address;
            tr_data[tr_n] <= m_writedata;
            tr_cyc[tr_n]  <= cyc;
            tr_n          <= tr_n + 1;
        end
        if ((m_write && m_read) || (m_chipselect !== (m_write || m_read)))
            bus_viol <= bus_viol + 1;
    end

    typedef struct {
        int          zp;
        logic [31:0] fst;
        logic [31:0] nonce;
        logic        e_found;
        logic        e_to;
        logic [31:0] e_nonce;
        int          e_st;
        int          e_nr;
    } vec_t;

    vec_t vecs[6];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tgt_word(input int tag, input int k);
        if (tag == 0) return (k == 7) ? 32'h0000_0000 : 32'hFFFF_FFFF;
        else          return {tag[7:0], 8'h5A, k[15:0]};
    endfunction

    function automatic logic [31:0] msg_word(input int tag, input int k);
        if (tag == 0) return 32'(k + 1);
        else          return {tag[7:0], 8'hC3, k[15:0]};
    endfunction

    task automatic run_job(input int v, input int tag);
        int base, n, hold_bad, snap, hs, nst, nnr, nother, bad_wr, bad_tm, bad_sp, last_st, first_rd;
        logic [37:0] exp_e;
        @(negedge clk);
        zero_polls   = vecs[v].zp;
        final_status = vecs[v].fst;
        nonce_val    = vecs[v].nonce;
        st_base      = st_total;
        base         = tr_n;
        for (int k = 0; k < 8; k++)  job_target[k*32 +: 32]  = tgt_word(tag, k);
        for (int k = 0; k < 19; k++) job_message[k*32 +: 32] = msg_word(tag, k);
        job_valid = 1'b1;
        check64($sformatf("job_ready_idle v%0d", v), {63'd0, job_ready}, 64'd1);
        @(negedge clk);
        job_valid   = 1'b0;
        job_target  = ~job_target;
        job_message = ~job_message;
        n = 0;
        while (!result_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check64($sformatf("result_valid v%0d", v), {63'd0, result_valid}, 64'd1);
        check64($sformatf("result v%0d {found,timeout,nonce}", v),
                {30'd0, result_found, result_timeout, result_nonce},
                {30'd0, vecs[v].e_found, vecs[v].e_to, vecs[v].e_nonce});
        check64($sformatf("job_ready_busy v%0d", v), {63'd0, job_ready}, 64'd0);
        // Hold the result while job_valid toggles: nothing may move.
        hold_bad = 0;
        snap = tr_n;
        for (int i = 0; i < 20; i++) begin
            job_valid = i[0];
            @(negedge clk);
            if (result_valid !== 1'b1 || job_ready !== 1'b0 || result_found !== vecs[v].e_found ||
                result_timeout !== vecs[v].e_to || result_nonce !== vecs[v].e_nonce ||
                m_write || m_read) hold_bad++;
        end
        job_valid = 1'b0;
        @(negedge clk);
        check64($sformatf("hold_stable v%0d", v), 64'(hold_bad), 64'd0);
        check64($sformatf("hold_no_bus v%0d", v), 64'(tr_n - snap), 64'd0);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check64($sformatf("release v%0d {valid,ready}", v), {62'd0, result_valid, job_ready}, 64'd1);
        // Trace analysis.
        hs = hs_edge;
        check64($sformatf("bus_count v%0d", v), 64'(tr_n - base), 64'(30 + vecs[v].e_st + vecs[v].e_nr));
        bad_wr = 0;
        bad_tm = 0;
        for (int j = 0; j < 30; j++) begin
            if (j == 0)       exp_e = {1'b1, 5'd1, 32'd0};
            else if (j < 9)   exp_e = {1'b1, 5'(j + 1), tgt_word(tag, j - 1)};
            else if (j < 28)  exp_e = {1'b1, 5'(j + 2), msg_word(tag, j - 9)};
            else if (j == 28) exp_e = {1'b1, 5'd1, 32'd1};
            else              exp_e = {1'b1, 5'd1, 32'd3};
            if (base + j >= tr_n) bad_wr++;
            else begin
                if ({tr_we[base+j], tr_addr[base+j], tr_data[base+j]} !== exp_e) begin
                    bad_wr++;
                    if (bad_wr == 1)
                        $display("FAIL write v%0d slot %0d: got 0x%0h expected 0x%0h",
                                 v, j, {tr_we[base+j], tr_addr[base+j], tr_data[base+j]}, exp_e);
                end
                if (tr_cyc[base+j] != hs + j) bad_tm++;
            end
        end
        check64($sformatf("write_seq_bad v%0d", v), 64'(bad_wr), 64'd0);
        check64($sformatf("write_timing_bad v%0d", v), 64'(bad_tm), 64'd0);
        nst = 0; nnr = 0; nother = 0; bad_sp = 0; last_st = 0; first_rd = -1;
        for (int j = base + 30; j < tr_n; j++) begin
            if (tr_we[j]) nother++;
            else if (tr_addr[j] == 5'd0) begin
                if (first_rd < 0) first_rd = tr_cyc[j];
                else if (tr_cyc[j] - last_st != 10) bad_sp++;
                last_st = tr_cyc[j];
                nst++;
            end else if (tr_addr[j] == 5'd10) nnr++;
            else nother++;
        end
        check64($sformatf("first_read_latency v%0d", v), 64'(first_rd - hs), 64'd38);
        check64($sformatf("poll_spacing_bad v%0d", v), 64'(bad_sp), 64'd0);
        check64($sformatf("status_reads v%0d", v), 64'(nst), 64'(vecs[v].e_st));
        check64($sformatf("nonce_reads v%0d", v), 64'(nnr), 64'(vecs[v].e_nr));
        check64($sformatf("stray_access v%0d", v), 64'(nother), 64'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{zp: 3,   fst: 32'h3, nonce: 32'h0000_1234, e_found: 1'b1, e_to: 1'b0, e_nonce: 32'h0000_1234, e_st: 4, e_nr: 1};
        vecs[1] = '{zp: 0,   fst: 32'h2, nonce: 32'h5555_5555, e_found: 1'b0, e_to: 1'b0, e_nonce: 32'h0,          e_st: 1, e_nr: 0};
        vecs[2] = '{zp: 100, fst: 32'h3, nonce: 32'h7777_7777, e_found: 1'b0, e_to: 1'b1, e_nonce: 32'h0,          e_st: 5, e_nr: 0};
        vecs[3] = '{zp: 0,   fst: 32'h3, nonce: 32'hDEAD_BEEF, e_found: 1'b1, e_to: 1'b0, e_nonce: 32'hDEAD_BEEF, e_st: 1, e_nr: 1};
        vecs[4] = '{zp: 4,   fst: 32'h2, nonce: 32'h1111_1111, e_found: 1'b0, e_to: 1'b0, e_nonce: 32'h0,          e_st: 5, e_nr: 0};
        vecs[5] = '{zp: 5,   fst: 32'h3, nonce: 32'h2222_2222, e_found: 1'b0, e_to: 1'b1, e_nonce: 32'h0,          e_st: 5, e_nr: 0};

        rst          = 1'b1;
        job_valid    = 1'b0;
        result_ready = 1'b0;
        job_target   = '0;
        job_message  = '0;
        repeat (3) @(negedge clk);
        check64("reset {job_ready,valid,found,timeout,wr,rd,cs}",
                {57'd0, job_ready, result_valid, result_found, result_timeout, m_write, m_read, m_chipselect},
                {57'd0, 7'b1000000});
        check64("reset {addr,wdata,nonce}", {m_address, m_writedata, result_nonce[26:0]}, 64'd0);
        check64("reset nonce_hi", {59'd0, result_nonce[31:27]}, 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) run_job(v, v);

        // Reset in the middle of the message writes.
        @(negedge clk);
        zero_polls = 0;
        final_status = 32'h2;
        for (int k = 0; k < 8; k++)  job_target[k*32 +: 32]  = tgt_word(7, k);
        for (int k = 0; k < 19; k++) job_message[k*32 +: 32] = msg_word(7, k);
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        n = 0;
        while (!(m_write && m_address == 5'd15) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check64("reached_addr15", {63'd0, (m_write && m_address == 5'd15)}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check64("midreset {wr,rd,cs,job_ready,valid}",
                {59'd0, m_write, m_read, m_chipselect, job_ready, result_valid}, {59'd0, 5'b00010});
        rst = 1'b0;
        @(negedge clk);
        check64("after_reset_idle {wr,rd,addr}", {57'd0, m_write, m_read, m_address}, 64'd0);
        run_job(3, 8);

        check64("bus_rule_violations", 64'(bus_viol), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/miner_job_master.md
Name: miner_job_master

Overview:
- Avalon-MM master that drives the miner's register-mapped slave port from the host side.
- Accepts one mining job (256-bit target, 608-bit message) over a valid/ready handshake and writes the job into the miner's CSRs.
- Triggers load-target then load-message, then polls the result registers until the miner reports complete (or a poll timeout fires).
- Returns found/nonce to the requester over a second valid/ready handshake. Sits between a host/DMA job source and the miner top level.

Parameters:
- POLL_INTERVAL, 8, idle cycles between status reads; legal minimum 4.
- READ_LATENCY, 1, cycles from read issue to valid m_readdata; range 1-3.
- TIMEOUT_POLLS, 65535, status reads without complete before a timeout result is returned; 16-bit counter.
- STATUS_ADDR, 0, read address of the status word: bit0 found, bit1 complete.
- NONCE_ADDR, 10, read address of the found nonce.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  job offered.
- job_ready  out  1  block can accept a job.
- job_target  in  256  target; bits [32k+31:32k] go to CSR address 2+k, for k=0..7.
- job_message  in  608  header without nonce; bits [32k+31:32k] go to CSR address 11+k, for k=0..18.
- result_valid  out  1  result held for the requester.
- result_ready  in  1  requester consumes the result.
- result_found  out  1  miner found a nonce.
- result_timeout  out  1  poll limit reached without complete.
- result_nonce  out  32  found nonce; 0 when not found.
- m_address  out  5  Avalon address.
- m_writedata  out  32  write data.
- m_write  out  1  write strobe.
- m_read  out  1  read strobe.
- m_chipselect  out  1  asserted in any cycle with m_write or m_read.
- m_readdata  in  32  read data, valid READ_LATENCY cycles after m_read.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state IDLE; job_ready=1.
  - All Avalon strobes 0; m_address=0; m_writedata=0.
  - result_valid=0; result_found=0; result_timeout=0; result_nonce=0.
  - Counters cleared. Reset mid-job abandons the job immediately, with no further bus activity.
- Bus rules:
  - The slave has no waitrequest, so each access is exactly one cycle.
  - At most one strobe per cycle; m_write and m_read are never high together.
- States:
  - IDLE: job_ready=1. On job_valid&&job_ready, latch target and message into internal registers and go to CLR. job_ready=0 in every other state.
  - CLR: write 0x0 to address 1, so the next control write produces fresh rising edges.
  - WR_TGT: 8 consecutive writes, addresses 2..9 ascending.
  - WR_MSG: 19 consecutive writes, addresses 11..29 ascending.
  - LT: write 0x1 to address 1 (newTarget edge).
  - LM: write 0x3 to address 1 (newMsg edge; bit0 held so no extra target edge). This write also clears the miner's stale results.
  - WAIT: count POLL_INTERVAL idle cycles; the poll counter starts at 0 on entry from LM.
  - RD_ST: one-cycle read of STATUS_ADDR, then wait READ_LATENCY cycles and sample m_readdata.
    - bit1=1 and bit0=1: go to RD_NONCE.
    - bit1=1 and bit0=0: found=0, nonce=0, go to DONE.
    - bit1=0: increment the poll counter. If the count equals TIMEOUT_POLLS, set timeout=1 and go to DONE; else go to WAIT.
  - RD_NONCE: read NONCE_ADDR, sample after READ_LATENCY, set found=1, go to DONE.
  - DONE: result_valid=1, outputs stable until result_ready. On result_valid&&result_ready, clear result_valid and go to IDLE. The next job can be accepted in the following cycle.
- Latency: a job handshake to the first status read takes 1+8+19+1+1+POLL_INTERVAL cycles, i.e. 38 cycles at default.
- result_found and result_timeout are never both 1.
- job_valid is ignored in all states except IDLE; latched job data is immune to input changes after acceptance.

Test Plan:
- Reset then job with target=0x00000000_FFFF...(word7=0), message words k=k+1: bus trace shows write 0→addr1, addr2..9 then 11..29 carrying the correct words, then 0x1→addr1, 0x3→addr1, and the first read of addr0 exactly 38 cycles after the handshake.
- Slave model returns status 0x0 for 3 polls, then 0x3, and nonce 0x0000_1234 at addr10: result_valid with found=1, nonce=0x1234, timeout=0. Polls are spaced POLL_INTERVAL+READ_LATENCY+1 cycles apart.
- Status 0x2 (complete, not found): result found=0, nonce=0, with no read of addr10.
- TIMEOUT_POLLS=5, status always 0: exactly 5 status reads, then result timeout=1, found=0.
- Hold result_ready=0 for 20 cycles and toggle job_valid: outputs stable, job_ready=0, no bus activity. On result_ready=1, return to IDLE and accept a second job the next cycle.
- Assert rst during WR_MSG (address 15): the next cycle has all strobes 0, job_ready=1, and a new job restarts from CLR.
